// File: rtl/merge_rr.sv
// merge_rr: N-master to single-slave merger with round-robin arbitration, one transaction at a time.
// Optional watchdog (sticky timeout output) is built when MERGE_RR_TIMEOUT_EN is defined.
`ifndef REQ_W
`define REQ_W 35
`endif
`ifndef RESP_W
`define RESP_W 17
`endif
// REQ_W packs {valid, addr[15:0], wdata[15:0], wstrb[1:0]}; RESP_W packs {rdata[15:0], ready}.

module merge_rr #(
  parameter int N_MASTERS   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS*`REQ_W-1:0]  m_req,
  output logic [N_MASTERS*`RESP_W-1:0] m_resp,
  output logic [`REQ_W-1:0]            s_req,
  input  logic [`RESP_W-1:0]           s_resp,
  output logic [$clog2(N_MASTERS)-1:0] grant,
  output logic                         busy
`ifdef MERGE_RR_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  // Handshake: a master owns the slave from the grant edge until the cycle
  // s_resp.ready is 1; that cycle's response is routed to the owner only.
  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d, ptr_q, ptr_d, grant_inc, pick_idx;
  logic [N_MASTERS-1:0] valid_v;
  logic                 pick_found, s_ready, finish, tmo_fire;
  int                   best_dist, cand_dist;

  if (N_MASTERS < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("merge_rr: N_MASTERS must be >= 2 and TIMEOUT_CYC >= 1");
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
    assign valid_v[i] = m_req[i*`REQ_W + `REQ_W - 1];
  end

  assign s_ready = s_resp[0];

  // First valid master at or after ptr: smallest circular distance from ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best_dist  = N_MASTERS;
    cand_dist  = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand_dist = (i >= int'(ptr_q)) ? i - int'(ptr_q) : i + N_MASTERS - int'(ptr_q);
      if (valid_v[i] && cand_dist < best_dist) begin
        best_dist  = cand_dist;
        pick_found = 1'b1;
        pick_idx   = GW'(i);
      end
    end
  end

  assign grant_inc = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);

`ifdef MERGE_RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // A real ready in the limit cycle completes normally and does not count as a timeout.
  assign tmo_fire = (state_q == BUSY) && !s_ready && (cnt_q == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != BUSY)
        cnt_q <= '0;
      else if (!s_ready && !tmo_fire)
        cnt_q <= cnt_q + CW'(1);
      if (tmo_fire)
        timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_fire = 1'b0;
`endif

  assign finish = s_ready || tmo_fire;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = pick_idx;
        end
      end
      BUSY: begin
        if (finish) begin
          state_d = IDLE;
          ptr_d   = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Forwarding is purely combinational from the registered owner.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant_q == GW'(i)) begin
          s_req = m_req[i*`REQ_W +: `REQ_W];
          m_resp[i*`RESP_W +: `RESP_W] = tmo_fire ? `RESP_W'(1) : s_resp;
        end
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_merge_rr.sv
// Self-checking bench for merge_rr: directed scenarios on a 2-master and a 4-master instance,
// plus randomized traffic on the 4-master instance against a transaction-level reference model.
`ifndef REQ_W
`define REQ_W 35
`endif
`ifndef RESP_W
`define RESP_W 17
`endif

module tb_merge_rr;

  localparam int RW  = `REQ_W;
  localparam int PW  = `RESP_W;
  localparam int N4  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2*RW-1:0]  m_req2;
  logic [2*PW-1:0]  m_resp2;
  logic [RW-1:0]    s_req2;
  logic [PW-1:0]    s_resp2;
  logic [0:0]       grant2;
  logic             busy2;
  logic [N4*RW-1:0] m_req4;
  logic [N4*PW-1:0] m_resp4;
  logic [RW-1:0]    s_req4;
  logic [PW-1:0]    s_resp4;
  logic [1:0]       grant4;
  logic             busy4;
`ifdef MERGE_RR_TIMEOUT_EN
  logic             timeout2, timeout4;
`endif

  merge_rr #(.N_MASTERS(2)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2), .s_req(s_req2),
    .s_resp(s_resp2), .grant(grant2), .busy(busy2)
`ifdef MERGE_RR_TIMEOUT_EN
    , .timeout(timeout2)
`endif
  );

  merge_rr #(.N_MASTERS(N4), .TIMEOUT_CYC(TMO)) dut4 (
    .clk(clk), .rst(rst), .m_req(m_req4), .m_resp(m_resp4), .s_req(s_req4),
    .s_resp(s_resp4), .grant(grant4), .busy(busy4)
`ifdef MERGE_RR_TIMEOUT_EN
    , .timeout(timeout4)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  // Reference model of the 4-master instance: owner (-1 when idle), rotating pointer, watchdog.
  int mdl_own, mdl_ptr, mdl_cnt, mdl_last;
  bit mdl_tmo;

  function automatic logic [RW-1:0] mk_req(bit v, logic [15:0] a, logic [15:0] d, logic [1:0] s);
    return {v, a, d, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    mdl_own = -1; mdl_ptr = 0; mdl_cnt = 0; mdl_last = 0; mdl_tmo = 0;
  endtask

  function automatic bit mdl_fire();
`ifdef MERGE_RR_TIMEOUT_EN
    return (mdl_own >= 0) && !s_resp4[0] && (mdl_cnt == TMO);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic mdl_step();
    int j;
    bit fire;
    fire = mdl_fire();
    if (mdl_own < 0) begin
      for (int k = 0; k < N4; k++) begin
        j = (mdl_ptr + k) % N4;
        if (m_req4[j*RW + RW - 1] && mdl_own < 0) begin
          mdl_own = j; mdl_last = j; mdl_cnt = 0;
        end
      end
    end else if (s_resp4[0] || fire) begin
      if (!s_resp4[0]) mdl_tmo = 1;
      mdl_ptr = (mdl_own + 1) % N4;
      mdl_own = -1;
    end else begin
      mdl_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req2 = '0; m_req4 = '0; s_resp2 = '0; s_resp4 = '0;
    tick();
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_req2 = '0; m_req4 = '0; s_resp2 = '0; s_resp4 = '0;
    repeat (2) tick();
    rst = 1'b0;
    m_req2[1*RW +: RW] = mk_req(1, 16'h1111, 16'h2222, 2'b11);
    m_req4[3*RW +: RW] = mk_req(1, 16'h3333, 16'h4444, 2'b01);
    repeat (3) tick();
    rst = 1'b1;
    s_resp2 = {16'hAAAA, 1'b1};
    s_resp4 = {16'hBBBB, 1'b1};
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%0b exp=0", busy2); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%0b exp=0", busy4); end
    checks++; if (grant2 !== 1'd0) begin failures++; $display("FAIL reset_grant2 got=%0d exp=0", grant2); end
    checks++; if (grant4 !== 2'd0) begin failures++; $display("FAIL reset_grant4 got=%0d exp=0", grant4); end
    checks++; if (s_req2 !== '0) begin failures++; $display("FAIL reset_sreq2 got=%h exp=0", s_req2); end
    checks++; if (s_req4 !== '0) begin failures++; $display("FAIL reset_sreq4 got=%h exp=0", s_req4); end
    checks++; if (m_resp2 !== '0) begin failures++; $display("FAIL reset_mresp2 got=%h exp=0", m_resp2); end
    checks++; if (m_resp4 !== '0) begin failures++; $display("FAIL reset_mresp4 got=%h exp=0", m_resp4); end
`ifdef MERGE_RR_TIMEOUT_EN
    checks++; if (timeout2 !== 1'b0) begin failures++; $display("FAIL reset_timeout2 got=%0b exp=0", timeout2); end
    checks++; if (timeout4 !== 1'b0) begin failures++; $display("FAIL reset_timeout4 got=%0b exp=0", timeout4); end
`endif
  endtask

  // Master 1 alone on the 2-master instance, ready three cycles after valid, then ptr back at 0.
  task automatic test_single_master();
    logic [RW-1:0] r1, r0;
    do_reset();
    r1 = mk_req(1, 16'h0101, 16'h5555, 2'b10);
    m_req2[1*RW +: RW] = r1;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL single_arb_busy got=%0b exp=0", busy2); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) s_resp2 = {16'hCAFE, 1'b1};
      @(negedge clk);
      checks++; if (busy2 !== 1'b1 || grant2 !== 1'd1) begin failures++; $display("FAIL single_grant c=%0d got=%0b/%0d exp=1/1", c, busy2, grant2); end
      checks++; if (s_req2 !== r1) begin failures++; $display("FAIL single_sreq c=%0d got=%h exp=%h", c, s_req2, r1); end
      checks++; if (m_resp2[0 +: PW] !== '0) begin failures++; $display("FAIL single_m0_resp c=%0d got=%h exp=0", c, m_resp2[0 +: PW]); end
      if (c == 3) begin
        checks++; if (m_resp2[PW +: PW] !== {16'hCAFE, 1'b1}) begin failures++; $display("FAIL single_m1_resp got=%h exp=%h", m_resp2[PW +: PW], {16'hCAFE, 1'b1}); end
      end else begin
        checks++; if (m_resp2[PW +: PW] !== '0) begin failures++; $display("FAIL single_m1_stall c=%0d got=%h exp=0", c, m_resp2[PW +: PW]); end
      end
      tick();
    end
    r0 = mk_req(1, 16'h0202, 16'h6666, 2'b01);
    m_req2[0 +: RW] = r0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0 || m_resp2 !== '0) begin failures++; $display("FAIL single_idle got=%0b/%h exp=0/0", busy2, m_resp2); end
    tick();
    @(negedge clk);
    checks++; if (busy2 !== 1'b1 || grant2 !== 1'd0) begin failures++; $display("FAIL single_ptr_wrap got=%0b/%0d exp=1/0", busy2, grant2); end
  endtask

  // All four masters valid continuously, slave answers in the second BUSY cycle.
  task automatic test_back_to_back();
    bit ready_next, was_busy, seen;
    int gap, cyc;
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < N4; i++)
      m_req4[i*RW +: RW] = mk_req(1, 16'($urandom), 16'($urandom), 2'($urandom));
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ready_next = 0; was_busy = 0; seen = 0; gap = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      s_resp4 = {16'(cyc), ready_next};
      @(negedge clk);
      if (busy4) begin
        if (!was_busy) begin
          exp_g = exp_q.pop_front();
          checks++; if (grant4 !== exp_g) begin failures++; $display("FAIL b2b_grant got=%0d exp=%0d", grant4, exp_g); end
          if (seen) begin
            checks++; if (gap != 1) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=1", gap); end
          end
          seen = 1; gap = 0;
        end
        ready_next = !s_resp4[0];
      end else begin
        gap++;
        ready_next = 0;
      end
      was_busy = busy4;
      tick();
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_bound pending=%0d exp=0", exp_q.size()); end
  endtask

  // m0 granted, slave stalls 10 cycles, m1 arrives at cycle 2 and must wait.
  task automatic test_stall();
    do_reset();
    m_req2[0 +: RW] = mk_req(1, 16'h0A0A, 16'h0B0B, 2'b11);
    tick();
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) m_req2[RW +: RW] = mk_req(1, 16'h1A1A, 16'h1B1B, 2'b00);
      s_resp2 = {16'h7777, (c == 11)};
      @(negedge clk);
      checks++; if (busy2 !== 1'b1 || grant2 !== 1'd0) begin failures++; $display("FAIL stall_hold c=%0d got=%0b/%0d exp=1/0", c, busy2, grant2); end
      checks++; if (m_resp2[PW] !== 1'b0) begin failures++; $display("FAIL stall_m1_ready c=%0d got=%0b exp=0", c, m_resp2[PW]); end
      checks++; if (m_resp2[0] !== (c == 11)) begin failures++; $display("FAIL stall_m0_ready c=%0d got=%0b exp=%0b", c, m_resp2[0], (c == 11)); end
      tick();
    end
    m_req2[0 +: RW] = '0;
    s_resp2 = '0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0b exp=0", busy2); end
    tick();
    @(negedge clk);
    checks++; if (busy2 !== 1'b1 || grant2 !== 1'd1) begin failures++; $display("FAIL stall_next got=%0b/%0d exp=1/1", busy2, grant2); end
  endtask

  // Reset pulsed in the second BUSY cycle abandons the transaction.
  task automatic test_reset_mid();
    do_reset();
    m_req2[RW +: RW] = mk_req(1, 16'hC0C0, 16'hD0D0, 2'b10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_req2 = '0;
    s_resp2 = {16'hBEEF, 1'b1};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (busy2 !== 1'b0 || grant2 !== 1'd0) begin failures++; $display("FAIL rstmid_state c=%0d got=%0b/%0d exp=0/0", c, busy2, grant2); end
      checks++; if (s_req2[RW-1] !== 1'b0) begin failures++; $display("FAIL rstmid_svalid c=%0d got=%0b exp=0", c, s_req2[RW-1]); end
      checks++; if (m_resp2 !== '0) begin failures++; $display("FAIL rstmid_resp c=%0d got=%h exp=0", c, m_resp2); end
      tick();
    end
  endtask

  // Owner drops valid mid-transaction: forwarded valid follows, grant and ready still go to it.
  task automatic test_drop_valid();
    logic [RW-1:0] r0;
    do_reset();
    r0 = mk_req(1, 16'h1234, 16'h9876, 2'b01);
    m_req2[0 +: RW] = r0;
    tick();
    tick();
    r0[RW-1] = 1'b0;
    m_req2[0 +: RW] = r0;
    m_req2[RW +: RW] = mk_req(1, 16'h4321, 16'h6789, 2'b10);
    @(negedge clk);
    checks++; if (s_req2 !== r0) begin failures++; $display("FAIL drop_sreq got=%h exp=%h", s_req2, r0); end
    checks++; if (busy2 !== 1'b1 || grant2 !== 1'd0) begin failures++; $display("FAIL drop_hold got=%0b/%0d exp=1/0", busy2, grant2); end
    tick();
    s_resp2 = {16'h5A5A, 1'b1};
    @(negedge clk);
    checks++; if (m_resp2[0 +: PW] !== {16'h5A5A, 1'b1}) begin failures++; $display("FAIL drop_ready got=%h exp=%h", m_resp2[0 +: PW], {16'h5A5A, 1'b1}); end
    checks++; if (m_resp2[PW +: PW] !== '0) begin failures++; $display("FAIL drop_other got=%h exp=0", m_resp2[PW +: PW]); end
    tick();
    s_resp2 = '0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL drop_done got=%0b exp=0", busy2); end
  endtask

`ifdef MERGE_RR_TIMEOUT_EN
  // Slave never answers: after TMO stalled BUSY cycles the owner gets a zero-data ready.
  task automatic test_timeout();
    logic [N4*PW-1:0] exp_resp;
    do_reset();
    m_req4[2*RW +: RW] = mk_req(1, 16'hFACE, 16'hF00D, 2'b11);
    s_resp4 = {16'hDEAD, 1'b0};
    tick();
    for (int c = 1; c <= TMO + 1; c++) begin
      exp_resp = '0;
      if (c == TMO + 1) exp_resp[2*PW +: PW] = PW'(1);
      @(negedge clk);
      checks++; if (busy4 !== 1'b1 || grant4 !== 2'd2) begin failures++; $display("FAIL tmo_hold c=%0d got=%0b/%0d exp=1/2", c, busy4, grant4); end
      checks++; if (m_resp4 !== exp_resp) begin failures++; $display("FAIL tmo_resp c=%0d got=%h exp=%h", c, m_resp4, exp_resp); end
      checks++; if (timeout4 !== 1'b0) begin failures++; $display("FAIL tmo_early c=%0d got=%0b exp=0", c, timeout4); end
      tick();
    end
    m_req4 = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (busy4 !== 1'b0 || timeout4 !== 1'b1) begin failures++; $display("FAIL tmo_after c=%0d got=%0b/%0b exp=0/1", c, busy4, timeout4); end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [RW-1:0]    r;
    logic [RW-1:0]    exp_sreq;
    logic [N4*PW-1:0] exp_mresp;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N4; i++) begin
        r = mk_req($urandom_range(0, 99) < 35, 16'($urandom), 16'($urandom), 2'($urandom));
        m_req4[i*RW +: RW] = r;
      end
      s_resp4 = {16'($urandom), $urandom_range(0, 99) < 40};
      @(negedge clk);
      exp_sreq  = '0;
      exp_mresp = '0;
      if (mdl_own >= 0) begin
        exp_sreq = m_req4[mdl_own*RW +: RW];
        exp_mresp[mdl_own*PW +: PW] = mdl_fire() ? PW'(1) : s_resp4;
      end
      checks++; if (busy4 !== (mdl_own >= 0)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", cyc, busy4, (mdl_own >= 0)); end
      checks++; if (grant4 !== 2'(mdl_last)) begin failures++; $display("FAIL rand_grant cyc=%0d got=%0d exp=%0d", cyc, grant4, mdl_last); end
      checks++; if (s_req4 !== exp_sreq) begin failures++; $display("FAIL rand_sreq cyc=%0d got=%h exp=%h", cyc, s_req4, exp_sreq); end
      checks++; if (m_resp4 !== exp_mresp) begin failures++; $display("FAIL rand_mresp cyc=%0d got=%h exp=%h", cyc, m_resp4, exp_mresp); end
`ifdef MERGE_RR_TIMEOUT_EN
      checks++; if (timeout4 !== mdl_tmo) begin failures++; $display("FAIL rand_timeout cyc=%0d got=%0b exp=%0b", cyc, timeout4, mdl_tmo); end
`endif
      @(posedge clk);
      mdl_step();
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset();
    test_reset();
    test_single_master();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_drop_valid();
`ifdef MERGE_RR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merge_rr.md
MERGE_RR -- requirements
Module: merge_rr

Interface
REQ-001 Parameter N_MASTERS, default 2, number of requesting masters (>=2).
REQ-002 Parameter TIMEOUT_CYC, default 255, watchdog limit in cycles, used only with MERGE_RR_TIMEOUT_EN.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m_req  input  N_MASTERS*`REQ_W  packed master requests {valid, addr, wdata, wstrb}; master i at slice i.
REQ-006 m_resp  output  N_MASTERS*`RESP_W  packed master responses {rdata, ready}; master i at slice i.
REQ-007 s_req  output  `REQ_W  request to the single slave.
REQ-008 s_resp  input  `RESP_W  response from the single slave.
REQ-009 grant  output  $clog2(N_MASTERS)  index of the currently granted master.
REQ-010 busy  output  1  high while a transaction is owned by a master.
REQ-011 timeout  output  1  sticky watchdog flag; present only with MERGE_RR_TIMEOUT_EN.

Function
REQ-012 FSM states IDLE and BUSY; IDLE -> BUSY when any m_req valid is high; BUSY -> IDLE in the cycle after s_resp ready is high.
REQ-013 In IDLE, grant is chosen round-robin: the first valid master at or after pointer ptr, wrapping from N_MASTERS-1 to 0, registered at the clock edge (1-cycle arbitration latency).
REQ-014 In BUSY, s_req equals m_req of master grant, combinationally.
REQ-015 In IDLE, s_req valid is 0; other s_req fields are don't-care, driven 0.
REQ-016 s_resp is routed combinationally to m_resp of master grant only while BUSY.
REQ-017 Non-granted masters, and all masters in IDLE, see ready=0 and rdata=0.
REQ-018 On completion (BUSY and s_resp ready=1), ptr becomes (grant+1) mod N_MASTERS.
REQ-019 Grant is held for the whole transaction, including while the slave stalls ready low for any number of cycles.
REQ-020 Grant is held even if the granted master drops valid early (protocol violation); forwarded valid follows the master, and the transaction ends only on ready.
REQ-021 Simultaneous valid from all masters: each master is served exactly once per N_MASTERS transactions.
REQ-022 A new request seen in the completion cycle is arbitrated in the next IDLE cycle; there are no back-to-back grants without one IDLE cycle.
REQ-023 busy = (state == BUSY); grant is undefined-free and holds its last value while in IDLE.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, ptr=0, grant=0, busy=0, timeout=0; s_req valid=0 and all m_resp ready=0 from the following cycle.
REQ-025 Reset asserted mid-transaction abandons the transaction; no ready is delivered to the owner.

Configuration
REQ-026 Macro MERGE_RR_TIMEOUT_EN defined: a counter clears on entering BUSY and increments each BUSY cycle without s_resp ready.
REQ-027 With the macro defined, if the counter reaches TIMEOUT_CYC, the granted master receives ready=1, rdata=0 for one cycle, the FSM returns to IDLE, ptr advances, and timeout sets until rst.
REQ-028 Macro MERGE_RR_TIMEOUT_EN undefined: no counter, no timeout port, and BUSY waits indefinitely for ready.

Verification
REQ-029 N=2, master 1 valid alone, slave ready 3 cycles later, rdata=0xCAFE -> grant=1, m1 sees ready with 0xCAFE, m0 sees ready=0, ptr=0 afterwards.
REQ-030 N=4, all masters valid continuously, slave ready 1 cycle after valid -> grant sequence 0,1,2,3,0 with one IDLE cycle between grants.
REQ-031 m0 granted, slave stalls 10 cycles, m1 raises valid at cycle 2 -> grant stays 0 until ready; m1 granted next.
REQ-032 rst pulsed during BUSY at cycle 2 -> next cycle s_req valid=0, busy=0, grant=0, no ready to any master.
REQ-033 MERGE_RR_TIMEOUT_EN, TIMEOUT_CYC=8, slave never ready -> after 8 BUSY cycles owner gets ready=1 with rdata=0, timeout=1, FSM in IDLE.
REQ-034 Granted master drops valid mid-transaction -> s_req valid=0 and grant held; the later ready is still delivered to that master.
